// File: rtl/enc_4x2_pope_seq.sv
// -----------------------------------------------------------------------------
// enc_4x2_pope_seq
//
// Registered 4-to-2 priority encoder with a positive enable and valid/ready
// handshakes on both sides. It is the encoding counterpart of the 2x4
// positive-output, positive-enable decoder.
//
// A 4-bit request vector d is captured when the producer offers it and the
// block is ready. Each capture produces:
//   y     - index of the highest set bit (d[3] = A is highest priority)
//   v     - at least one request bit was set
//   multi - two or more request bits were set
// The result is held until the consumer takes it. Accepted multi-hot vectors
// are counted in a saturating counter for error reporting.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   E          in   1      positive enable, gates input acceptance only
//   d          in   4      request vector, d[3]=A (highest) .. d[0]=D
//   in_valid   in   1      producer presents d
//   in_ready   out  1      block can accept d this cycle (combinational)
//   y          out  2      encoded index of the captured vector
//   v          out  1      captured vector was non-zero
//   multi      out  1      captured vector had two or more bits set
//   out_valid  out  1      y/v/multi hold an unconsumed result
//   out_ready  in   1      consumer takes the result this cycle
//   err_cnt    out  ERR_W  saturating count of accepted multi-hot vectors
// -----------------------------------------------------------------------------
module enc_4x2_pope_seq #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [3:0]       d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       y,
    output logic             v,
    output logic             multi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;

    logic [1:0]       r_y;
    logic             r_v;
    logic             r_multi;
    logic [ERR_W-1:0] r_err;

    // Index of the highest set bit. An all-zero vector encodes as 00 and is
    // told apart from a lone d[0] by the v flag.
    function automatic logic [1:0] f_prio(input logic [3:0] vec);
        logic [1:0] idx;
        if (vec[3]) begin
            idx = 2'b11;
        end else if (vec[2]) begin
            idx = 2'b10;
        end else if (vec[1]) begin
            idx = 2'b01;
        end else begin
            idx = 2'b00;
        end
        return idx;
    endfunction

    // True when two or more request bits are set.
    function automatic logic f_multi(input logic [3:0] vec);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            cnt = cnt + {2'b00, vec[i]};
        end
        return (cnt >= 3'd2);
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] f_sat_inc(input logic [ERR_W-1:0] cnt);
        logic [ERR_W-1:0] res;
        if (&cnt) begin
            res = cnt;
        end else begin
            res = cnt + ERR_W'(1);
        end
        return res;
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                // A consume with a simultaneous accept keeps HOLD, giving
                // one result per cycle when both sides stream.
                if (out_ready && !w_accept) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: output logic ----------------
    // in_ready looks at out_ready directly so that a held result being taken
    // this cycle frees the register for a new capture at the same edge.
    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_out_valid = 1'b0;
                w_in_ready  = E;
            end
            HOLD: begin
                w_out_valid = 1'b1;
                w_in_ready  = E & out_ready;
            end
            default: begin
                w_out_valid = 1'b0;
                w_in_ready  = 1'b0;
            end
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    // ---------------- Result and error-count registers ----------------
    // Reset clears the held result as well, so a result pending at reset is
    // discarded and never re-presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= 2'b00;
            r_v     <= 1'b0;
            r_multi <= 1'b0;
            r_err   <= '0;
        end else if (w_accept) begin
            r_y     <= f_prio(d);
            r_v     <= |d;
            r_multi <= f_multi(d);
            if (f_multi(d)) begin
                r_err <= f_sat_inc(r_err);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign y         = r_y;
    assign v         = r_v;
    assign multi     = r_multi;
    assign err_cnt   = r_err;

endmodule
